std_fifo_param: RTL

Parametrised successor to the standard synchronous FIFO: single clock, configurable data width, depth and almost-flag thresholds.
- Adds sticky overflow/underflow error flags with a clear input.
- Optional first-word-fall-through read mode.
- Used as the general buffering primitive between pipeline stages inside one clock domain.

---
 rtl/std_fifo_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/std_fifo_param.sv
// std_fifo_param: parametrised single-clock FIFO with registered occupancy
// flags, almost-full/almost-empty thresholds and sticky overflow/underflow
// error flags.
// Optional build macro STD_FIFO_PARAM_FWFT_EN selects first-word-fall-through
// reads; without it, q updates one cycle after an accepted pop.
module std_fifo_param #(
    parameter int WIDTH               = 8,
    parameter int DEPTH               = 64,
    parameter int ALMOST_FULL_MARGIN  = 4,
    parameter int ALMOST_EMPTY_MARGIN = 4,
    localparam int CW                 = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam int              AF_TH    = DEPTH - ALMOST_FULL_MARGIN;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             push_ok;
    logic             pop_ok;

    // Requests are qualified against the registered flags only, so a push
    // while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    // Next-state for pointers, occupancy, flags and read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q_d      = q_q;

        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            // In FWFT builds this register only supplies the value held
            // on q while the FIFO is empty: the last word handed out.
            q_d      = mem[rd_ptr_q];
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        afull_d  = (int'(count_d) >= AF_TH);
        aempty_d = (int'(count_d) <= ALMOST_EMPTY_MARGIN);

        // A violation on the same edge as clr_err leaves the flag set.
        if (push && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (pop && empty_q) begin
            unf_d = 1'b1;
        end else if (clr_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            q_q      <= q_d;
        end
    end

    // Storage array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= d;
        end
    end

`ifdef STD_FIFO_PARAM_FWFT_EN
    // Head word is presented directly; a freshly pushed word into an empty
    // FIFO becomes visible the same cycle empty drops.
    assign q = empty_q ? q_q : mem[rd_ptr_q];
`else
    assign q = q_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign count        = count_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
